// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states and
// access-size helpers used by both the responder and its lane aligner.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Undefined encodings (011, 11x) fall through to word accesses.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      F3_LW:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3_size(f3))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data/strobes from funct3 and address, and
// sign/zero extension of the selected lane of a returned read word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  size_t       w_size;
  logic        w_signed;
  logic [31:0] w_shifted;

  assign w_size    = f3_size(i_funct3);
  assign w_signed  = (i_funct3 == F3_LB) || (i_funct3 == F3_LH);
  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (w_size)
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: turns load/store requests into word-aligned req/ack bus
// transactions and stalls the pipeline until done. DMEM_STORE_BUF_EN adds a posted write buffer.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BUS_AW = 30
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_memreadm,
  input  logic              i_memwritem,
  input  logic [2:0]        i_funct3m,
  input  logic [XLEN-1:0]   i_addrm,
  input  logic [XLEN-1:0]   i_writedatam,
  output logic [XLEN-1:0]   o_readdatam,
  output logic              o_stallm,
  output logic              o_misalignm,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [BUS_AW-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_wstrb,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_ack
);

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_rdata;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [BUS_AW-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wstrb;

  logic              w_access;
  logic              w_misal;
  logic              w_ack;
  logic              w_start;
  logic              w_post;
  logic [2:0]        w_al_f3;
  logic [1:0]        w_al_addr;
  logic [3:0]        w_st_wstrb;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_ld_data;

  assign w_access = i_memreadm | i_memwritem;
  assign w_misal  = f3_misaligned(i_funct3m, i_addrm[1:0]);
  assign w_ack    = i_bus_ack & r_bus_req;

`ifdef DMEM_STORE_BUF_EN
  logic r_wbuf_full;
  // Nothing new reaches the bus while a posted store is draining; loads never overtake it.
  assign w_post  = (r_state == S_IDLE) && i_memwritem && !w_misal && !r_wbuf_full;
  assign w_start = (r_state == S_IDLE) && i_memreadm && !i_memwritem && !w_misal && !r_wbuf_full;
`else
  assign w_post  = 1'b0;
  assign w_start = (r_state == S_IDLE) && w_access && !w_misal;
`endif

  assign o_stallm    = ((r_state == S_IDLE) && w_access && !w_misal && !w_post) ||
                       (r_state == S_BUSY);
  assign o_misalignm = !i_reset && (r_state == S_IDLE) && w_access && w_misal;

  // DONE extends the captured word with the attributes latched at request time.
  assign w_al_f3   = (r_state == S_DONE) ? r_funct3  : i_funct3m;
  assign w_al_addr = (r_state == S_DONE) ? r_addr_lo : i_addrm[1:0];

  dmem_lane_align u_align (
    .i_funct3  (w_al_f3),
    .i_addr_lo (w_al_addr),
    .i_wdata   (i_writedatam[31:0]),
    .i_rword   (r_rdata),
    .o_wstrb   (w_st_wstrb),
    .o_wdata   (w_st_wdata),
    .o_rdata   (w_ld_data)
  );

  assign o_readdatam = (r_state == S_DONE) ? w_ld_data : '0;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_wstrb = r_bus_wstrb;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
`ifdef DMEM_STORE_BUF_EN
      r_wbuf_full <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start || w_post) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= i_memwritem;
            r_bus_addr  <= i_addrm[BUS_AW+1:2];
            r_bus_wdata <= w_st_wdata;
            r_bus_wstrb <= w_st_wstrb;
            r_funct3    <= i_funct3m;
            r_addr_lo   <= i_addrm[1:0];
          end
          if (w_start) r_state <= S_BUSY;
`ifdef DMEM_STORE_BUF_EN
          if (w_ack) begin
            r_bus_req   <= 1'b0;
            r_wbuf_full <= 1'b0;
          end
          if (w_post) r_wbuf_full <= 1'b1;
`endif
        end
        S_BUSY: begin
          if (w_ack) begin
            r_rdata   <= i_bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        // The access still visible here is the retiring one, so never restart from DONE.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random loads/stores checked against a
// byte-level reference memory and arithmetic lane/extension rules.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadm, memwritem;
  logic [2:0]  funct3m;
  logic [31:0] addrm, writedatam;
  logic [31:0] o_readdatam;
  logic        o_stallm, o_misalignm;
  logic        o_bus_req, o_bus_we;
  logic [29:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_errors = 0;
  int g_dly    = 0;
  int age      = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .BUS_AW(30)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_memreadm   (memreadm),
    .i_memwritem  (memwritem),
    .i_funct3m    (funct3m),
    .i_addrm      (addrm),
    .i_writedatam (writedatam),
    .o_readdatam  (o_readdatam),
    .o_stallm     (o_stallm),
    .o_misalignm  (o_misalignm),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_wstrb  (o_bus_wstrb),
    .i_bus_rdata  (bus_rdata),
    .i_bus_ack    (bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = (1 << acc_size(f3)) - 1;
    return 4'(m << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (acc_size(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    if (acc_size(f3) == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (acc_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] b, tmp;
    for (int k = 0; k < acc_size(f3); k++) begin
      b   = addr + k;
      tmp = wd >> (8 * k);
      ref_mem[b[9:2]][8*b[1:0] +: 8] = tmp[7:0];
    end
  endtask

  // Backing memory: acks g_dly cycles after bus_req rises, applying strobed writes.
  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (!o_bus_req || reset) begin
      age = 0;
    end else begin
      if (age == g_dly) begin
        bus_ack   = 1'b1;
        bus_rdata = mem[o_bus_addr[7:0]];
        if (o_bus_we)
          for (int i = 0; i < 4; i++)
            if (o_bus_wstrb[i]) mem[o_bus_addr[7:0]][8*i +: 8] = o_bus_wdata[8*i +: 8];
      end
      age++;
    end
  end

  // Called just after a rising edge; returns just after the edge where the access retires.
  task automatic txn(input logic re, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd_got, output int stalls);
    bit done = 0;
    logic [31:0] exp_rd = '0;
    memreadm = re; memwritem = we; funct3m = f3; addrm = addr; writedatam = wd;
    stalls = 0;
    rd_got = '0;
    if (is_misal(f3, addr)) begin
      @(negedge clk);
      check("misalign", o_misalignm, 1);
      check("misal_stall", o_stallm, 0);
      check("misal_rdata", o_readdatam, 0);
`ifndef DMEM_STORE_BUF_EN
      check("misal_noreq", o_bus_req, 0);
`endif
    end else begin
      if (we) ref_store(f3, addr, wd);
      else    exp_rd = exp_load(f3, addr, ref_mem[addr[9:2]]);
      for (int c = 0; c < 64 && !done; c++) begin
        @(negedge clk);
        check("no_misal", o_misalignm, 0);
`ifndef DMEM_STORE_BUF_EN
        if (o_bus_req) begin
          check("bus_addr", o_bus_addr, addr >> 2);
          check("bus_we", o_bus_we, we);
          if (we) begin
            check("bus_wstrb", o_bus_wstrb, exp_strb(f3, addr));
            check("bus_wdata", o_bus_wdata, exp_wdata(f3, wd));
          end
        end
`endif
        if (o_stallm) stalls++;
        else          done = 1;
      end
      check("txn_done", done, 1);
      if (!we) begin
        rd_got = o_readdatam;
        check("readdata", o_readdatam, exp_rd);
      end
`ifndef DMEM_STORE_BUF_EN
      check("stall_cycles", stalls, g_dly + 2);
`endif
    end
    @(posedge clk); #1;
    memreadm = 1'b0; memwritem = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ra, rw;
    logic [2:0]  rf;
    int          st, op;
    bit          seen;

    reset = 1'b1; memreadm = 1'b0; memwritem = 1'b0;
    funct3m = '0; addrm = '0; writedatam = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", o_stallm, 0);
    check("rst_req", o_bus_req, 0);
    check("rst_we", o_bus_we, 0);
    check("rst_misal", o_misalignm, 0);
    check("rst_rdata", o_readdatam, 0);
    check("rst_addr", o_bus_addr, 0);
    check("rst_wdata", o_bus_wdata, 0);
    check("rst_wstrb", o_bus_wstrb, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    g_dly = 0;
    txn(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, rd, st);
    repeat (4) @(posedge clk);
    #1;
    mem[8'h40]     = 32'h80FF_0000;
    ref_mem[8'h40] = 32'h80FF_0000;
    txn(1, 0, 3'b000, 32'h103, 32'h0, rd, st);
    check("lb_value", rd, 32'hFFFF_FF80);
    txn(1, 0, 3'b100, 32'h103, 32'h0, rd, st);
    check("lbu_value", rd, 32'h0000_0080);
    txn(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, rd, st);
    txn(1, 0, 3'b010, 32'h100, 32'h0, rd, st);
    check("sh_readback", rd, 32'hABCD_0000);
    txn(1, 0, 3'b001, 32'h101, 32'h0, rd, st);

    g_dly = 5;
    txn(1, 0, 3'b010, 32'h204, 32'h0, rd, st);
    txn(0, 1, 3'b010, 32'h208, 32'h1357_9BDF, rd, st);
    repeat (8) @(posedge clk);
    #1;

    // Abandon a load mid-flight: the ack never comes before reset.
    g_dly = 1000;
    memreadm = 1'b1; funct3m = 3'b010; addrm = 32'h20C;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (o_bus_req) seen = 1;
    end
    check("rst_busy_req_seen", seen, 1);
    reset = 1'b1; memreadm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_req", o_bus_req, 0);
    check("rst_busy_stall", o_stallm, 0);
    reset = 1'b0;
    g_dly = 0;
    @(posedge clk); #1;

`ifdef DMEM_STORE_BUF_EN
    txn(0, 1, 3'b010, 32'h300, 32'h1234_5678, rd, st);
    check("buf_sw_stall", st, 0);
    txn(1, 0, 3'b010, 32'h300, 32'h0, rd, st);
    check("buf_lw_stall", st, 3);
    check("buf_lw_value", rd, 32'h1234_5678);
`endif

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(7, 0));
      ra = ($urandom_range(255, 0) << 2) | ($urandom_range(1, 0) ? $urandom_range(3, 0) : 0);
      rw = $urandom;
      op = $urandom_range(2, 0);
      g_dly = $urandom_range(3, 0);
      txn(op != 1, op != 0, rf, ra, rw, rd, st);
    end

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
